// File: rtl/dmem_responder_pkg.sv
// Shared types and helpers for the RV32I data-memory responder.
`timescale 1ns/1ps
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } dmem_state_e;

  // Request kind, packed as {MemWrite, MemRead}.
  typedef enum logic [1:0] {
    OP_NONE  = 2'b00,
    OP_LOAD  = 2'b01,
    OP_STORE = 2'b10,
    OP_BOTH  = 2'b11
  } dmem_op_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Latched request; addr is carried zero-extended to 32 bits.
  typedef struct packed {
    dmem_op_e    op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  func3;
  } dmem_req_t;

  // True when the request must be rejected: misaligned, bad size for the op,
  // or a simultaneous load and store.
  function automatic logic req_error(dmem_op_e op, logic [1:0] lane, logic [2:0] f3);
    logic err;
    err = 1'b1;
    case (op)
      OP_LOAD: begin
        case (f3)
          F3_B, F3_BU: err = 1'b0;
          F3_H, F3_HU: err = lane[0];
          F3_W:        err = (lane != 2'b00);
          default:     err = 1'b1;
        endcase
      end
      OP_STORE: begin
        case (f3)
          F3_B:    err = 1'b0;
          F3_H:    err = lane[0];
          F3_W:    err = (lane != 2'b00);
          default: err = 1'b1;
        endcase
      end
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// MEM-stage <-> data-memory request/response bundle.
`timescale 1ns/1ps
interface dmem_responder_if #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
);
  logic                  MemRead;
  logic                  MemWrite;
  logic [DM_ADDRESS-1:0] addr;
  logic [DATA_W-1:0]     wr_data;
  logic [2:0]            func3;
  logic [DATA_W-1:0]     rd_data;
  logic                  rd_valid;
  logic                  mem_stall;
  logic                  mem_err;

  modport master (
    output MemRead, MemWrite, addr, wr_data, func3,
    input  rd_data, rd_valid, mem_stall, mem_err
  );

  modport slave (
    input  MemRead, MemWrite, addr, wr_data, func3,
    output rd_data, rd_valid, mem_stall, mem_err
  );
endinterface

// File: rtl/dmem_responder_load_extend.sv
// Selects the byte/half/word addressed by a load and sign- or zero-extends it.
`timescale 1ns/1ps
module load_extend
  import dmem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  input  logic [2:0]  func3_i,
  output logic [31:0] data_o
);
  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane selection followed by extension according to the access size.
  always_comb begin
    byte_s = word_i[{lane_i, 3'b000} +: 8];
    half_s = lane_i[1] ? word_i[31:16] : word_i[15:0];
    case (func3_i)
      F3_B:    data_o = {{24{byte_s[7]}}, byte_s};
      F3_BU:   data_o = {24'h000000, byte_s};
      F3_H:    data_o = {{16{half_s[15]}}, half_s};
      F3_HU:   data_o = {16'h0000, half_s};
      F3_W:    data_o = word_i;
      default: data_o = 32'h0000_0000;
    endcase
  end
endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: wait-state FSM, word store with read-modify-write
// merge, and sized load return for the MEM stage.
`timescale 1ns/1ps
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DM_ADDRESS  = 9,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2
) (
  input logic              clk,
  input logic              reset,
  dmem_responder_if.slave  bus
);
  localparam int         WORDS    = 2 ** (DM_ADDRESS - 2);
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  dmem_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  dmem_req_t   req_q, req_d;
  logic        err_q, err_d;
  logic [31:0] mem_q [WORDS];

  logic                  req_valid_s;
  dmem_op_e              op_s;
  logic [DM_ADDRESS-3:0] widx_s;
  logic [1:0]            lane_s;
  logic [31:0]           rd_word_s;
  logic [31:0]           merged_s;
  logic [31:0]           ext_s;
  logic                  do_store_s;
  logic                  load_ok_s;
  logic                  unused_addr_s;

  assign req_valid_s   = bus.MemRead | bus.MemWrite;
  assign op_s          = dmem_op_e'({bus.MemWrite, bus.MemRead});
  assign widx_s        = req_q.addr[DM_ADDRESS-1:2];
  assign lane_s        = req_q.addr[1:0];
  assign rd_word_s     = mem_q[widx_s];
  assign unused_addr_s = ^req_q.addr[31:DM_ADDRESS];

  load_extend u_load_extend (
    .word_i  (rd_word_s),
    .lane_i  (lane_s),
    .func3_i (req_q.func3),
    .data_o  (ext_s)
  );

  // Next-state, counter and request-latch logic of the wait-state FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid_s) begin
          req_d.op    = op_s;
          req_d.addr  = {{(32 - DM_ADDRESS){1'b0}}, bus.addr};
          req_d.wdata = bus.wr_data;
          req_d.func3 = bus.func3;
          err_d       = req_error(op_s, bus.addr[1:0], bus.func3);
          if (WAIT_CYCLES == 0) begin
            state_d = DONE;
          end else begin
            state_d = BUSY;
            cnt_d   = CNT_INIT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, counter and latched request registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      req_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      err_q   <= err_d;
    end
  end

  // Merge store data into the currently stored word (byte, half or full word).
  always_comb begin
    merged_s = rd_word_s;
    case (req_q.func3)
      F3_B: merged_s[{lane_s, 3'b000} +: 8] = req_q.wdata[7:0];
      F3_H: begin
        if (lane_s[1]) begin
          merged_s[31:16] = req_q.wdata[15:0];
        end else begin
          merged_s[15:0] = req_q.wdata[15:0];
        end
      end
      F3_W:    merged_s = req_q.wdata;
      default: merged_s = rd_word_s;
    endcase
  end

  assign do_store_s = (state_q == DONE) && (req_q.op == OP_STORE) && !err_q;
  assign load_ok_s  = (state_q == DONE) && (req_q.op == OP_LOAD) && !err_q;

  // Storage: cleared on reset, a legal store commits on the DONE edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < WORDS; i++) begin
        mem_q[i] <= 32'h0000_0000;
      end
    end else if (do_store_s) begin
      mem_q[widx_s] <= merged_s;
    end
  end

  // Response decode: stall is asserted from the accept cycle until DONE.
  always_comb begin
    bus.mem_stall = ((state_q == IDLE) && req_valid_s && !reset) || (state_q == BUSY);
    bus.rd_valid  = load_ok_s;
    bus.mem_err   = (state_q == DONE) && err_q;
    if (load_ok_s) begin
      bus.rd_data = DATA_W'(ext_s);
    end else begin
      bus.rd_data = '0;
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed, table-driven bench for dmem_responder (WAIT_CYCLES=2 and 0).
`timescale 1ns/1ps
module tb_dmem_responder;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  dmem_responder_if #(.DM_ADDRESS(9), .DATA_W(32)) bus0 ();
  dmem_responder_if #(.DM_ADDRESS(9), .DATA_W(32)) bus1 ();

  dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .WAIT_CYCLES(2)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0.slave)
  );

  dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .WAIT_CYCLES(0)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [8:0]  a;
    logic [31:0] wd;
    logic [2:0]  f3;
    logic [31:0] ed;
    logic        ev;
    logic        ee;
  } vec_t;

  vec_t vecs[22];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic idle0();
    bus0.MemRead  = 1'b0;
    bus0.MemWrite = 1'b0;
  endtask

  // One complete access on dut0, starting and ending at a negedge in IDLE.
  task automatic run_access(input string nm, input logic rd, input logic wr,
                            input logic [8:0] a, input logic [31:0] wd, input logic [2:0] f3,
                            input logic [31:0] ed, input logic ev, input logic ee,
                            input logic drop_mid);
    int stalls;
    int n;
    bus0.MemRead  = rd;
    bus0.MemWrite = wr;
    bus0.addr     = a;
    bus0.wr_data  = wd;
    bus0.func3    = f3;
    #1;
    stalls = 0;
    n = 0;
    while (bus0.mem_stall && n < 40) begin
      stalls++;
      n++;
      @(posedge clk);
      @(negedge clk);
      if (drop_mid) idle0();
      #1;
    end
    chk({nm, " stall_cycles"}, 32'(stalls), 32'd3);
    chk({nm, " rd_valid"}, {31'd0, bus0.rd_valid}, {31'd0, ev});
    chk({nm, " rd_data"}, bus0.rd_data, ed);
    chk({nm, " mem_err"}, {31'd0, bus0.mem_err}, {31'd0, ee});
    idle0();
    @(posedge clk);
    @(negedge clk);
    #1;
    chk({nm, " pulse_end"}, {30'd0, bus0.rd_valid, bus0.mem_err}, 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    //           rd    wr    addr    wdata          f3      exp_data       ev    ee
    vecs[0]  = '{1'b0, 1'b1, 9'h010, 32'h8000_00FF, 3'b010, 32'h0000_0000, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 9'h010, 32'h0000_0000, 3'b010, 32'h8000_00FF, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 9'h013, 32'h1234_56AB, 3'b000, 32'h0000_0000, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 9'h013, 32'h0000_0000, 3'b000, 32'hFFFF_FFAB, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 9'h013, 32'h0000_0000, 3'b100, 32'h0000_00AB, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 9'h010, 32'h0000_0000, 3'b010, 32'hAB00_00FF, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 9'h010, 32'h0000_0000, 3'b000, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 9'h010, 32'h0000_0000, 3'b100, 32'h0000_00FF, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 9'h012, 32'h0000_0000, 3'b001, 32'hFFFF_AB00, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 9'h021, 32'h0000_5555, 3'b001, 32'h0000_0000, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 9'h022, 32'h0000_0000, 3'b010, 32'h0000_0000, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 9'h020, 32'h0000_0000, 3'b010, 32'h0000_0000, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 9'h022, 32'hCAFE_BEEF, 3'b001, 32'h0000_0000, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 9'h022, 32'h0000_0000, 3'b001, 32'hFFFF_BEEF, 1'b1, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 9'h022, 32'h0000_0000, 3'b101, 32'h0000_BEEF, 1'b1, 1'b0};
    vecs[15] = '{1'b1, 1'b0, 9'h020, 32'h0000_0000, 3'b010, 32'hBEEF_0000, 1'b1, 1'b0};
    vecs[16] = '{1'b1, 1'b0, 9'h020, 32'h0000_0000, 3'b011, 32'h0000_0000, 1'b0, 1'b1};
    vecs[17] = '{1'b0, 1'b1, 9'h020, 32'h1111_1111, 3'b100, 32'h0000_0000, 1'b0, 1'b1};
    vecs[18] = '{1'b1, 1'b0, 9'h020, 32'h0000_0000, 3'b010, 32'hBEEF_0000, 1'b1, 1'b0};
    vecs[19] = '{1'b1, 1'b1, 9'h040, 32'h1111_1111, 3'b010, 32'h0000_0000, 1'b0, 1'b1};
    vecs[20] = '{1'b0, 1'b1, 9'h042, 32'h2222_2222, 3'b010, 32'h0000_0000, 1'b0, 1'b1};
    vecs[21] = '{1'b1, 1'b0, 9'h040, 32'h0000_0000, 3'b010, 32'h0000_0000, 1'b1, 1'b0};

    // Reset with a request present: it must be ignored.
    reset = 1'b1;
    bus0.MemRead = 1'b1; bus0.MemWrite = 1'b0; bus0.addr = 9'h010;
    bus0.wr_data = 32'h0; bus0.func3 = 3'b010;
    bus1.MemRead = 1'b0; bus1.MemWrite = 1'b0; bus1.addr = 9'h000;
    bus1.wr_data = 32'h0; bus1.func3 = 3'b010;
    repeat (3) @(negedge clk);
    #1;
    chk("reset mem_stall", {31'd0, bus0.mem_stall}, 32'd0);
    chk("reset rd_valid", {31'd0, bus0.rd_valid}, 32'd0);
    chk("reset rd_data", bus0.rd_data, 32'd0);
    chk("reset mem_err", {31'd0, bus0.mem_err}, 32'd0);
    idle0();
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);

    for (int i = 0; i < 22; i++) begin
      run_access($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].wd,
                 vecs[i].f3, vecs[i].ed, vecs[i].ev, vecs[i].ee, 1'b0);
    end

    // Store whose request is dropped in BUSY still commits.
    run_access("flush_sw", 1'b0, 1'b1, 9'h050, 32'h5A5A_1234, 3'b010, 32'h0, 1'b0, 1'b0, 1'b1);
    run_access("flush_lw", 1'b1, 1'b0, 9'h050, 32'h0, 3'b010, 32'h5A5A_1234, 1'b1, 1'b0, 1'b0);

    // Reset during BUSY of a store: abort, no write, storage cleared.
    bus0.MemWrite = 1'b1; bus0.addr = 9'h030; bus0.wr_data = 32'hCAFE_F00D; bus0.func3 = 3'b010;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    idle0();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_mid mem_stall", {31'd0, bus0.mem_stall}, 32'd0);
    chk("rst_mid rd_valid", {31'd0, bus0.rd_valid}, 32'd0);
    chk("rst_mid rd_data", bus0.rd_data, 32'd0);
    chk("rst_mid mem_err", {31'd0, bus0.mem_err}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    run_access("rst_lw030", 1'b1, 1'b0, 9'h030, 32'h0, 3'b010, 32'h0, 1'b1, 1'b0, 1'b0);
    run_access("rst_lw010", 1'b1, 1'b0, 9'h010, 32'h0, 3'b010, 32'h0, 1'b1, 1'b0, 1'b0);

    // Zero wait states: SW, then back-to-back LW/LW with the request held.
    bus1.MemWrite = 1'b1; bus1.addr = 9'h004; bus1.wr_data = 32'hDEAD_BEEF; bus1.func3 = 3'b010;
    #1;
    chk("w0 sw stall_idle", {31'd0, bus1.mem_stall}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("w0 sw stall_done", {31'd0, bus1.mem_stall}, 32'd0);
    chk("w0 sw mem_err", {31'd0, bus1.mem_err}, 32'd0);
    bus1.MemWrite = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus1.MemRead = 1'b1;
    #1;
    chk("w0 lw1 stall_idle", {31'd0, bus1.mem_stall}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("w0 lw1 stall_done", {31'd0, bus1.mem_stall}, 32'd0);
    chk("w0 lw1 rd_valid", {31'd0, bus1.rd_valid}, 32'd1);
    chk("w0 lw1 rd_data", bus1.rd_data, 32'hDEAD_BEEF);
    bus1.addr = 9'h000;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("w0 lw2 stall_idle", {31'd0, bus1.mem_stall}, 32'd1);
    chk("w0 lw2 rd_valid_idle", {31'd0, bus1.rd_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("w0 lw2 stall_done", {31'd0, bus1.mem_stall}, 32'd0);
    chk("w0 lw2 rd_valid", {31'd0, bus1.rd_valid}, 32'd1);
    chk("w0 lw2 rd_data", bus1.rd_data, 32'h0000_0000);
    bus1.MemRead = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("w0 end rd_valid", {31'd0, bus1.rd_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
